uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Byte buffer and launch sequencer sitting directly upstream of the team's UART transmitter. It accepts bytes from any producer through a simple write strobe and stores them in a circular FIFO. It feeds them one at a time to the transmitter using its tx_start / tx_input / tx_ready / tx_sending handshake. The producer never has to track transmitter timing.

Parameters:
ADDR_W, 4, log2 of FIFO depth; depth = 2^ADDR_W entries (default 16).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset); sampled on rising clk.
wr_data  input  8  byte to enqueue.
wr_en  input  1  enqueue strobe; one byte per cycle while high.
full  output  1  FIFO holds 2^ADDR_W bytes.
empty  output  1  FIFO holds 0 bytes.
level  output  ADDR_W+1  current occupancy, 0..2^ADDR_W.
overflow  output  1  sticky: a write was attempted while full.
ovf_clr  input  1  clears overflow.
tx_input  output  8  byte presented to transmitter.
tx_start  output  1  launch request to transmitter.
tx_ready  input  1  transmitter idle (registered, from transmitter).
tx_sending  input  1  transmitter shifting (registered, from transmitter).

Behaviour:
- Reset (reset=0 at clk edge): rd/wr pointers=0, level=0, empty=1, full=0, overflow=0, tx_start=0, tx_input=8'h00, FSM=IDLE. Applies mid-transfer: queued bytes are discarded and tx_start drops the next cycle. The byte already shifting in the transmitter is not this block's concern.
- Storage: 2^ADDR_W x 8 register array. Pointers are ADDR_W bits and wrap naturally. level is a separate ADDR_W+1 counter.
- Write: wr_en=1 and full=0 -> mem[wr_ptr]<=wr_data, wr_ptr++ on that edge.
- Write while full: data is dropped and overflow<=1. This holds even if a pop occurs in the same cycle.
- overflow: ovf_clr=1 clears it. If ovf_clr and a dropped write coincide, set wins.
- Pop: occurs only on the REQ->WAIT transition (below), rd_ptr++.
- Simultaneous push and pop: level unchanged, both pointers advance.
- full, empty and level are registered and reflect the state after the edge.
- FSM (registered, 3 states):
  - IDLE: tx_start=0. If empty=0 and tx_ready=1 and tx_sending=0: tx_input<=mem[rd_ptr], tx_start<=1, go REQ.
  - REQ: hold tx_start=1 and tx_input stable. The transmitter samples tx_input continuously while idle and only leaves idle on its baud tick, so tx_input must not change in REQ. When tx_sending=1: tx_start<=0, pop, go WAIT.
  - WAIT: tx_start=0. When tx_ready=1 and tx_sending=0 (frame complete, transmitter back in idle): go IDLE.
- A byte written while the FSM is in IDLE with FIFO empty can launch no earlier than the cycle after it is written (empty must first clear). Minimum write-to-tx_start latency is 2 clk.
- tx_start deasserts exactly one cycle after tx_sending is first seen high. The transmitter stays busy far longer than this, so no double launch occurs.
- Back-to-back bytes: each byte costs one full transmitter frame plus at most 3 clk of FSM overhead. There is no bubble beyond that.
- tx_input holds the last launched byte in WAIT/IDLE; it changes only on IDLE->REQ.
- Width rules: level arithmetic is unsigned ADDR_W+1 bits and never wraps (guarded by full/empty).

Test Plan:
1. Reset with the transmitter model idle, then write 8'hA5 once -> tx_start rises 2 clk later with tx_input=8'hA5. tx_start falls 1 clk after tx_sending rises. level returns 0. The serial line carries 0xA5 LSB-first.
2. Burst-write 0x00..0x0F in 16 consecutive cycles (ADDR_W=4) -> full=1 and level=16 after the 16th. All 16 bytes emerge in order, one launch per tx_ready, with no duplicates.
3. Write 17 bytes back-to-back while the transmitter is held busy (tx_ready=0) -> the 17th is dropped and overflow=1. Pulsing ovf_clr clears it; overflow stays cleared on the next non-full write.
4. Hold level=16 in WAIT, then assert wr_en in the same cycle the pop occurs -> the write is dropped, overflow=1, level=15.
5. With 5 bytes queued, assert reset=0 for 1 clk during REQ -> next cycle tx_start=0, empty=1, level=0, FSM idle. No further launches occur until a new write.
6. Change wr_data every cycle while in REQ with tx_sending delayed 40 clk -> tx_input stays constant for all 40 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through a three-state launch sequencer.
// Write-to-tx_start is 2 clk minimum; writes while full are dropped and flagged sticky in overflow.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        tx_input,
  output logic              tx_start,
  input  logic              tx_ready,
  input  logic              tx_sending
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q, level_d;
  logic                full_q, empty_q;
  logic                ovf_q, ovf_d;
  logic                start_q, start_d;
  logic [7:0]          tx_dat_q, tx_dat_d;
  logic                push, drop, pop;

  assign push  = wr_en & ~full_q;
  assign drop  = wr_en & full_q;
  assign ovf_d = drop | (ovf_q & ~ovf_clr);

  // tx_input is only reloaded on IDLE->REQ so the transmitter sees a stable byte until it starts.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    tx_dat_d = tx_dat_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && tx_ready && !tx_sending) begin
          tx_dat_d = mem_q[rd_ptr_q];
          start_d  = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        start_d = 1'b1;
        if (tx_sending) begin
          start_d = 1'b0;
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tx_ready && !tx_sending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      tx_dat_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_FULL);
      empty_q  <= (level_d == '0);
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      tx_dat_q <= tx_dat_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign tx_input = tx_dat_q;
  assign tx_start = start_q;

endmodule
